// File: rtl/spi_slave_wishbone.sv
// spi_slave_wishbone
//   SPI mode-0 slave (MSB first, 8-bit frames) with an RX byte FIFO that is
//   read over a minimal Wishbone-style register port. All SPI pins are
//   oversampled on CLK_I; sck must run at no more than CLK_I/8.
//
// Optional feature: define SPI_SLAVE_TX_EN to build the TX path. A DATA write
//   then loads a holding register that is shifted out on miso. Without the
//   macro, miso is tied low and DATA writes are acknowledged and dropped.
//
// Parameters
//   FIFO_DEPTH  : RX FIFO depth (2, 4 or 8)
//   SYNC_STAGES : synchronizer flops on sck/mosi/cs (>= 2)
//
// Ports
//   CLK_I, RST_I      : system clock, async active-low reset
//   STB_I, WE_I       : Wishbone strobe / write enable
//   ADR_I, DAT_I      : register address (0x00 DATA, 0x01 STATUS), write data
//   ACK_O, RTY_O      : one-cycle acknowledge, retry (DATA read with FIFO empty)
//   DAT_O             : read data, valid while ACK_O=1
//   sck, mosi, cs     : SPI inputs from the master (cs active-low)
//   miso              : SPI output to the master, always driven
module spi_slave_wishbone #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic       WE_I,
  input  logic [7:0] ADR_I,
  input  logic [7:0] DAT_I,
  output logic       ACK_O,
  output logic       RTY_O,
  output logic [7:0] DAT_O,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs,
  output logic       miso
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [7:0] ADR_DATA   = 8'h00;
  localparam logic [7:0] ADR_STATUS = 8'h01;

  // ---------------------------------------------------------------------
  // Synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
  logic                   sck_d, cs_d;
  logic [SYNC_STAGES:0]   settle;
  logic                   sck_s, mosi_s, cs_s;
  logic                   sck_rise, cs_rise, cs_fall, ready;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      settle    <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;
  // The chain resets to cs idle; if the pin is already low when reset is
  // released, that would look like a falling edge. Ignore edges until the
  // chain and the edge flop hold real pin samples.
  assign ready    = settle[SYNC_STAGES];

  // ---------------------------------------------------------------------
  // RX framing and shift register
  // ---------------------------------------------------------------------
  logic       framed;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic       push_req;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      framed   <= 1'b0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      push_req <= 1'b0;
    end else begin
      push_req <= 1'b0;
      if (cs_rise) begin
        framed  <= 1'b0;
        bit_cnt <= '0;
      end else if (cs_fall && ready) begin
        framed  <= 1'b1;
        bit_cnt <= '0;
      end else if (sck_rise && framed && !cs_s) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) push_req <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full;
  logic          access, rd_data, status_rd, pop, push, ovf_set;
  logic          ovf;
  logic [3:0]    cnt4;
  logic [2:0]    cnt_sat;
  logic [7:0]    status;

  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign access    = STB_I & ~ACK_O;
  assign rd_data   = access & ~WE_I & (ADR_I == ADR_DATA);
  assign status_rd = access & ~WE_I & (ADR_I == ADR_STATUS);
  assign pop       = rd_data & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign push      = push_req & (~full | pop);
  assign ovf_set   = push_req & full & ~pop;

  assign cnt4    = 4'(count);
  assign cnt_sat = cnt4[3] ? 3'd7 : cnt4[2:0];
  assign status  = {1'b0, cnt_sat, ~cs_s, ovf, full, ~empty};

  always_ff @(posedge CLK_I) begin
    if (push) mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Setting wins over the clear-on-read so a same-cycle overflow survives.
      if (ovf_set)        ovf <= 1'b1;
      else if (status_rd) ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Wishbone response
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ACK_O <= 1'b0;
      RTY_O <= 1'b0;
      DAT_O <= '0;
    end else begin
      ACK_O <= access;
      RTY_O <= 1'b0;
      DAT_O <= '0;
      if (access && !WE_I) begin
        case (ADR_I)
          ADR_DATA: begin
            if (empty) RTY_O <= 1'b1;
            else       DAT_O <= mem[rd_ptr];
          end
          ADR_STATUS: DAT_O <= status;
          default:    DAT_O <= '0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------
`ifdef SPI_SLAVE_TX_EN
  logic [7:0] tx_hold, tx_shift;
  logic [2:0] tx_cnt;
  logic       sck_fall;

  assign sck_fall = ~sck_s & sck_d;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      tx_hold  <= '0;
      tx_shift <= '0;
      tx_cnt   <= '0;
    end else begin
      if (access && WE_I && (ADR_I == ADR_DATA)) tx_hold <= DAT_I;
      if (cs_fall && ready) begin
        tx_shift <= tx_hold;
        tx_cnt   <= '0;
      end else if (sck_fall && framed && !cs_s) begin
        tx_cnt <= tx_cnt + 3'd1;
        // The eighth falling edge closes the byte: reload for the next one.
        if (tx_cnt == 3'd7) tx_shift <= tx_hold;
        else                tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  assign miso = ~cs_s & tx_shift[7];
`else
  logic unused_dat;
  assign unused_dat = ^DAT_I;
  assign miso       = 1'b0;
`endif

endmodule
